// File: rtl/tx_mux_pkg.sv
// Purpose : shared types and helpers for the tx_arb_mux frame-aware transmit mux.
// Latency : n/a (types, constants and a combinational helper only).
// Backpr. : n/a.
// Contents: FSM state encoding (IDLE/BUSY) and a one-hot to index conversion.
package tx_mux_pkg;

  localparam logic IDLE_ENC = 1'b0;
  localparam logic BUSY_ENC = 1'b1;

  typedef enum logic {
    ST_IDLE = IDLE_ENC,
    ST_BUSY = BUSY_ENC
  } state_t;

  // Widest one-hot vector oh_to_idx accepts; callers zero-extend into it.
  localparam int OH_MAX_W = 32;

  // Index of the set bit of a one-hot vector (0 when the vector is empty).
  function automatic int oh_to_idx(input logic [OH_MAX_W-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < OH_MAX_W; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/tx_arb_mux_rr_arbiter.sv
// Purpose : combinational arbiter, one-hot grant to the first requester found
//           searching upward (modulo N) from ptr.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller decides when to sample the grant.
// Ports   : req  [N-1:0]  request vector
//           ptr  [PW-1:0] search start index (must be < N)
//           gnt  [N-1:0]  one-hot grant, all zero when req is zero
// Build   : TX_ARB_MUX_FIXED_PRIO_EN defined -> lowest requesting index wins, ptr ignored.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

`ifdef TX_ARB_MUX_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Isolate the lowest set bit.
  assign gnt = req & (~req + N'(1));

`else

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   pick_rot;
  logic [2*N-1:0] pick_dbl;
  logic           unused_bits;

  // Rotate so that index ptr sits at bit 0, take the lowest set bit, then
  // rotate the pick back into place.
  assign req_dbl  = {req, req} >> ptr;
  assign req_rot  = req_dbl[N-1:0];
  assign pick_rot = req_rot & (~req_rot + N'(1));
  assign pick_dbl = {pick_rot, pick_rot} << ptr;
  assign gnt      = pick_dbl[2*N-1:N];

  assign unused_bits = ^{req_dbl[2*N-1:N], pick_dbl[N-1:0]};

`endif

endmodule

// File: rtl/tx_arb_mux.sv
// Purpose : merges NUM_SW_INST valid/last frame streams onto one output,
//           locking the grant for a whole frame (round-robin between frames).
// Latency : 1 cycle input beat to registered output; first beat of a frame
//           appears 2 cycles after in_valid is seen in IDLE.
// Backpr. : out_ready low stalls the output register and drops in_ready of
//           the granted channel; nothing is lost or duplicated.
// Ports   : clk/rst (sync, active-high), in_valid/in_last/in_data/in_ready per
//           channel, out_valid/out_last/out_data/out_src/out_ready, grant (one-hot).
// Build   : TX_ARB_MUX_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module tx_arb_mux
  import tx_mux_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int FRAME_WIDTH = 32,
  parameter int SRC_W       = $clog2(NUM_SW_INST)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SW_INST-1:0]             in_valid,
  input  logic [NUM_SW_INST-1:0]             in_last,
  input  logic [FRAME_WIDTH*NUM_SW_INST-1:0] in_data,
  output logic [NUM_SW_INST-1:0]             in_ready,
  output logic                               out_valid,
  output logic                               out_last,
  output logic [FRAME_WIDTH-1:0]             out_data,
  output logic [SRC_W-1:0]                   out_src,
  input  logic                               out_ready,
  output logic [NUM_SW_INST-1:0]             grant
);

  state_t                  state_q, state_d;
  logic [NUM_SW_INST-1:0]  grant_q, grant_d;
  logic [SRC_W-1:0]        ptr_q, ptr_d;
  logic [NUM_SW_INST-1:0]  arb_gnt;

  logic                    out_valid_q;
  logic                    out_last_q;
  logic [FRAME_WIDTH-1:0]  out_data_q;
  logic [SRC_W-1:0]        out_src_q;

  logic [SRC_W-1:0]        sel;
  logic [FRAME_WIDTH-1:0]  sel_data;
  logic                    sel_last;
  logic                    sel_valid;
  logic                    out_free;
  logic                    accept;

  rr_arbiter #(
    .N  (NUM_SW_INST),
    .PW (SRC_W)
  ) u_arb (
    .req (in_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  // Beat mux driven straight from the one-hot grant register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (grant_q[i]) sel_data = sel_data | in_data[i*FRAME_WIDTH +: FRAME_WIDTH];
    end
  end

  assign sel       = SRC_W'(oh_to_idx(OH_MAX_W'(grant_q)));
  assign sel_last  = |(grant_q & in_last);
  assign sel_valid = |(grant_q & in_valid);

  // Output register can take a beat when empty or draining this cycle.
  assign out_free = ~out_valid_q | out_ready;
  assign accept   = (state_q == ST_BUSY) & out_free & sel_valid;
  assign in_ready = ((state_q == ST_BUSY) && out_free) ? grant_q : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|in_valid) begin
          grant_d = arb_gnt;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && sel_last) begin
          grant_d = '0;
          state_d = ST_IDLE;
`ifdef TX_ARB_MUX_FIXED_PRIO_EN
          ptr_d   = '0;
`else
          // Next search starts just past the channel that finished.
          ptr_d   = (sel == SRC_W'(NUM_SW_INST - 1)) ? '0 : sel + SRC_W'(1);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_last_q  <= sel_last;
      out_data_q  <= sel_data;
      out_src_q   <= sel;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_tx_arb_mux.sv
// Purpose : directed self-checking bench for tx_arb_mux (5 channels, 32-bit beats).
// Latency : n/a.
// Backpr. : exercises out_ready stalls and source-side valid gaps.
module tb_tx_arb_mux;

  localparam int N  = 5;
  localparam int FW = 32;
  localparam int SW = 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_last;
  logic [FW*N-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic            out_last;
  logic [FW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;
  logic [N-1:0]    grant;

  tx_arb_mux #(.NUM_SW_INST(N), .FRAME_WIDTH(FW), .SRC_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-channel source queues.
  logic [FW-1:0] bd [N][16];
  logic          bl [N][16];
  int            wr_n [N];
  int            rd_n [N];
  logic [N-1:0]  pause;

  // Output beats seen by the monitor.
  logic [FW-1:0] ob_data [64];
  logic [SW-1:0] ob_src  [64];
  logic          ob_last [64];
  int            ob_cyc  [64];
  int            ob_n;

  int cyc;
  int n_chk;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rd_n[i] < wr_n[i]) begin
        in_valid[i]           = ~pause[i];
        in_data[i*FW +: FW]   = bd[i][rd_n[i]];
        in_last[i]            = bl[i][rd_n[i]];
      end else begin
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic push(input int ch, input logic [FW-1:0] d, input logic l);
    bd[ch][wr_n[ch]] = d;
    bl[ch][wr_n[ch]] = l;
    wr_n[ch]++;
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) rd_n[i] = wr_n[i];
  endtask

  // One clock: sample handshakes at the falling edge, then advance the
  // queues and re-drive inputs just after the rising edge.
  task automatic step();
    logic [N-1:0] fire;
    @(negedge clk);
    fire = in_valid & in_ready;
    if (out_valid && out_ready && ob_n < 64) begin
      ob_data[ob_n] = out_data;
      ob_src[ob_n]  = out_src;
      ob_last[ob_n] = out_last;
      ob_cyc[ob_n]  = cyc;
      ob_n++;
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) if (fire[i]) rd_n[i]++;
    drive();
  endtask

  task automatic run_idle(input string tag);
    bit done;
    bit empty;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (rd_n[i] < wr_n[i]) empty = 1'b0;
      if (empty && !out_valid && grant == '0) done = 1'b1;
    end
    chk(tag, done, 1);
  endtask

  task automatic chk_beat(input string tag, input int k, input logic [FW-1:0] d,
                          input logic [SW-1:0] s, input logic l);
    chk($sformatf("%s_b%0d_data", tag, k), ob_data[k], d);
    chk($sformatf("%s_b%0d_src", tag, k), ob_src[k], s);
    chk($sformatf("%s_b%0d_last", tag, k), ob_last[k], l);
  endtask

  initial begin
    int n0;
    int es;
    n_chk = 0; n_fail = 0; cyc = 0; ob_n = 0;
    pause = '0;
    for (int i = 0; i < N; i++) begin wr_n[i] = 0; rd_n[i] = 0; end
    rst = 1'b1; out_ready = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0;

    // Reset state, with a channel requesting throughout.
    push(3, 32'hDEAD, 1'b1);
    drive();
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_out_src",   out_src, 0);
    chk("rst_grant",     grant, 0);
    chk("rst_in_ready",  in_ready, 0);
    flush(); drive();
    rst = 1'b0;
    step();

    // All channels with two single-beat frames each.
    ob_n = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push(i, 32'h100 + i*16 + k, 1'b1);
    drive();
    run_idle("rr_done");
    chk("rr_count", ob_n, 10);
    for (int k = 0; k < 10; k++) begin
`ifdef TX_ARB_MUX_FIXED_PRIO_EN
      es = k / 2;
      chk_beat("rr", k, 32'h100 + es*16 + (k % 2), SW'(es), 1'b1);
`else
      es = k % 5;
      chk_beat("rr", k, 32'h100 + es*16 + (k / 5), SW'(es), 1'b1);
`endif
    end
    chk("rr_gap", ob_cyc[1] - ob_cyc[0], 2);

    // Channel 2 three-beat frame: latency and framing.
    ob_n = 0;
    n0 = cyc;
    push(2, 32'hA0, 1'b0); push(2, 32'hA1, 1'b0); push(2, 32'hA2, 1'b1);
    drive();
    chk("t1_idle_grant", grant, 0);
    step();
    chk("t1_grant", grant, 5'b00100);
    chk("t1_noout", out_valid, 0);
    run_idle("t1_done");
    chk("t1_count", ob_n, 3);
    chk("t1_first_cyc", ob_cyc[0], n0 + 2);
    chk_beat("t1", 0, 32'hA0, 3'd2, 1'b0);
    chk_beat("t1", 1, 32'hA1, 3'd2, 1'b0);
    chk_beat("t1", 2, 32'hA2, 3'd2, 1'b1);

    // Channel 1 frame in progress; channels 0 and 2 request mid-frame.
    ob_n = 0;
    push(1, 32'hB0, 1'b0); push(1, 32'hB1, 1'b0); push(1, 32'hB2, 1'b1);
    drive();
    step(); step();
    push(0, 32'hC0, 1'b1); push(2, 32'hC2, 1'b1);
    drive();
    step();
    chk("t3_grant_held", grant, 5'b00010);
    run_idle("t3_done");
    chk("t3_count", ob_n, 5);
    chk_beat("t3", 0, 32'hB0, 3'd1, 1'b0);
    chk_beat("t3", 1, 32'hB1, 3'd1, 1'b0);
    chk_beat("t3", 2, 32'hB2, 3'd1, 1'b1);
`ifdef TX_ARB_MUX_FIXED_PRIO_EN
    chk_beat("t3", 3, 32'hC0, 3'd0, 1'b1);
    chk_beat("t3", 4, 32'hC2, 3'd2, 1'b1);
`else
    chk_beat("t3", 3, 32'hC2, 3'd2, 1'b1);
    chk_beat("t3", 4, 32'hC0, 3'd0, 1'b1);
`endif

    // out_ready low for 4 cycles mid-frame.
    ob_n = 0;
    push(3, 32'hD0, 1'b0); push(3, 32'hD1, 1'b0); push(3, 32'hD2, 1'b0); push(3, 32'hD3, 1'b1);
    drive();
    step(); step();
    out_ready = 1'b0;
    #1;
    chk("t4_in_ready_drop", in_ready, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t4_stall%0d_data", k), out_data, 32'hD0);
      chk($sformatf("t4_stall%0d_valid", k), out_valid, 1);
      chk($sformatf("t4_stall%0d_in_ready", k), in_ready, 0);
    end
    out_ready = 1'b1;
    run_idle("t4_done");
    chk("t4_count", ob_n, 4);
    for (int k = 0; k < 4; k++) chk_beat("t4", k, 32'hD0 + k, 3'd3, (k == 3));

    // Granted channel drops valid for 3 cycles; channel 0 waits meanwhile.
    ob_n = 0;
    push(4, 32'hE0, 1'b0); push(4, 32'hE1, 1'b0); push(4, 32'hE2, 1'b1);
    drive();
    step(); step();
    pause[4] = 1'b1;
    push(0, 32'hF0, 1'b1);
    drive();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t5_gap%0d_grant", k), grant, 5'b10000);
      chk($sformatf("t5_gap%0d_valid", k), out_valid, 0);
    end
    pause[4] = 1'b0;
    drive();
    run_idle("t5_done");
    chk("t5_count", ob_n, 4);
    chk_beat("t5", 0, 32'hE0, 3'd4, 1'b0);
    chk_beat("t5", 1, 32'hE1, 3'd4, 1'b0);
    chk_beat("t5", 2, 32'hE2, 3'd4, 1'b1);
    chk_beat("t5", 3, 32'hF0, 3'd0, 1'b1);

    // Reset mid-frame, then channels 0 and 3 compete.
    push(2, 32'h70, 1'b0); push(2, 32'h71, 1'b0); push(2, 32'h72, 1'b1);
    drive();
    step(); step();
    chk("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    step();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_last", out_last, 0);
    flush(); drive();
    rst = 1'b0;
    ob_n = 0;
    push(0, 32'h50, 1'b1); push(3, 32'h53, 1'b1);
    drive();
    run_idle("t6_done");
    chk("t6_count", ob_n, 2);
    chk_beat("t6", 0, 32'h50, 3'd0, 1'b1);
    chk_beat("t6", 1, 32'h53, 3'd3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_arb_mux.md
# tx_arb_mux

Frame-aware transmit multiplexer that merges NUM_SW_INST switch-instance frame streams onto one output stream. Replaces a sideband-select mux: each channel raises a valid/last stream, an internal arbiter grants one channel at a time and holds the grant for a whole multi-beat frame, and the output is a registered valid/ready stage. Sits between the per-instance TX buffers and the shared TX serializer.

## Interface
- NUM_SW_INST, 5, number of input channels (>=2)
- FRAME_WIDTH, 32, bits per data beat
- SRC_W, $clog2(NUM_SW_INST), width of source index output
- clk  input  1  single clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  NUM_SW_INST  per-channel beat valid
- in_last  input  NUM_SW_INST  per-channel last beat of frame
- in_data  input  FRAME_WIDTH*NUM_SW_INST  channel i at bits [i*FRAME_WIDTH +: FRAME_WIDTH]
- in_ready  output  NUM_SW_INST  per-channel beat accepted when valid&ready
- out_valid  output  1  registered output beat valid
- out_last  output  1  registered last flag
- out_data  output  FRAME_WIDTH  registered beat data
- out_src  output  SRC_W  index of channel that produced current beat
- out_ready  input  1  downstream accepts beat
- grant  output  NUM_SW_INST  one-hot current grant, all zero when idle

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if any in_valid, arbiter picks winner, grant register loads one-hot winner, go BUSY next cycle. in_ready all 0 in IDLE.
- BUSY: in_ready[g] = grant[g] & (~out_valid | out_ready); all other in_ready 0. Accepted beat loads out_data/out_last/out_src, sets out_valid.
- Accepted beat with in_last=1: grant cleared, return to IDLE, round-robin pointer set to granted index+1 (wrap NUM_SW_INST-1 -> 0).
- Round robin: search starts at pointer, first valid channel in ascending modulo order wins.
- out_valid clears when out_ready=1 and no new beat accepted the same cycle.
- Granted channel dropping in_valid mid-frame: grant held, bubble on output, no timeout.
- in_valid on non-granted channels ignored until IDLE; they must hold.
- in_last on a single-beat frame legal: one beat, back to IDLE.
- Reset (any time, including mid-frame): state IDLE, grant 0, pointer 0, out_valid 0, out_last 0, out_data 0, out_src 0, in_ready 0. Partial frame is dropped; downstream sees no out_last.

## Timing
- First beat: in_valid at cycle N (IDLE) -> grant at N+1 -> beat accepted N+1 -> out_valid at N+2.
- Steady beats: 1 beat/cycle while out_ready=1, latency 1 cycle input-to-output.
- Frame-to-frame gap: one IDLE cycle on input side between frames (max throughput L/(L+1) for L-beat frames).
- out_ready low: out_* stable, in_ready of granted channel low, no data loss.

## Configuration
- TX_ARB_MUX_FIXED_PRIO_EN defined: fixed priority, lowest index with in_valid wins, pointer unused (held 0).
- Not defined: round-robin as above (default).
- Frame locking, handshake and timing identical in both.

## Structure
- tx_mux_pkg: FSM state encoding (IDLE, BUSY) localparams, one-hot-to-index function.
- Sub-module rr_arbiter: request vector + pointer in, one-hot grant out, combinational; fixed-priority path selected inside it by the macro.
- Top holds FSM, grant/pointer registers, data mux and output register.

## Test plan
- Single channel 2 sends 3-beat frame 0xA0,0xA1,0xA2, out_ready=1 -> out_valid first at cycle N+2, out_src=2 on all beats, out_last only on 0xA2.
- All 5 channels valid with 1-beat frames continuously -> out_src order 0,1,2,3,4,0 (round-robin); with TX_ARB_MUX_FIXED_PRIO_EN -> always 0.
- Channel 1 frame in progress, channel 0 asserts valid -> channel 1 frame completes uninterrupted, then channel 2.. search from index 2 wins before 0.
- out_ready held low 4 cycles mid-frame -> out_data stable, in_ready[g]=0, no beat duplicated or lost after release.
- Granted channel deasserts in_valid 3 cycles mid-frame -> grant unchanged, out_valid gap, frame resumes intact.
- rst asserted mid-frame -> next cycle out_valid=0, grant=0, in_ready=0; after release, channel 0 wins first arbitration.
